dipsw_debounce: RTL



---
 rtl/dipsw_pkg.sv | 24 ++
 rtl/debounce_bit.sv | 133 +++++++++++++
 rtl/dipsw_debounce.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dipsw_pkg.sv
// -----------------------------------------------------------------------------
// dipsw_pkg
// Shared types and constants for the DIP switch debouncer.
//   bit_state_t   : per-bit debounce FSM state (IDLE / SETTLE)
//   glb_state_t   : global start-up FSM state (INIT / RUN)
//   STM_EVENT_W   : width of the HPS STM hardware event bus
//   STM_VALID_BIT : position of sw_valid on the STM event bus
// -----------------------------------------------------------------------------
package dipsw_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } bit_state_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } glb_state_t;

    localparam int unsigned STM_EVENT_W   = 28;
    localparam int unsigned STM_VALID_BIT = 27;

endpackage : dipsw_pkg

// File: rtl/debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One switch bit: SYNC_STAGES-deep synchronizer followed by a debounce counter
// and a two-state FSM. A new level is accepted only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current stable level.
//
// Ports
//   clk_clk     : fabric clock
//   reset_reset : asynchronous active-high reset
//   sw_async    : raw switch pin (asynchronous)
//   run_en      : high while the global FSM is in RUN; enables the bit FSM
//   init_load   : one-cycle strobe at the end of INIT; loads stable from the
//                 synchronized level without generating a change pulse
//   stable      : debounced level
//   change      : one-cycle pulse when stable toggles
// -----------------------------------------------------------------------------
module debounce_bit
    import dipsw_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic sw_async,
    input  logic run_en,
    input  logic init_load,
    output logic stable,
    output logic change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sw_sync;

    bit_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   stable_reg, stable_next;
    logic                   change_reg, change_next;

    logic                   mismatch;
    logic                   cnt_at_last;

    // Synchronizer: sample enters at bit 0, leaves at the top bit.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sw_async};
        end
    end

    assign sw_sync     = sync_reg[SYNC_STAGES-1];
    assign mismatch    = (sw_sync != stable_reg);
    assign cnt_at_last = (cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            change_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            change_reg <= change_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (init_load) begin
            state_next = IDLE;
        end else if (run_en) begin
            case (state_reg)
                IDLE: begin
                    if (mismatch) begin
                        state_next = SETTLE;
                    end
                end
                SETTLE: begin
                    // Bounce back or accept both return to IDLE.
                    if (!mismatch || cnt_at_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Counter / output logic
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        change_next = 1'b0;
        if (init_load) begin
            // Initial capture is silent: no change pulse.
            stable_next = sw_sync;
            cnt_next    = '0;
        end else if (run_en) begin
            case (state_reg)
                IDLE: begin
                    // The first mismatching sample already counts as one.
                    if (mismatch) begin
                        cnt_next = CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (!mismatch) begin
                        cnt_next = '0;
                    end else if (cnt_at_last) begin
                        stable_next = ~stable_reg;
                        change_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: cnt_next = '0;
            endcase
        end
    end

    assign stable = stable_reg;
    assign change = change_reg;

endmodule : debounce_bit

// File: rtl/dipsw_debounce.sv
// -----------------------------------------------------------------------------
// dipsw_debounce
// Conditions the raw DE0-Nano DIP switch pins for the HPS dipsw PIO. Each bit
// is synchronized and debounced independently; a shared start-up window
// (INIT, DEBOUNCE_CYCLES long) captures the initial switch levels silently and
// then raises sw_valid.
//
// Ports
//   clk_clk      : fabric clock (50 MHz)
//   reset_reset  : asynchronous active-high reset
//   sw_async     : raw switch pins [WIDTH-1:0]
//   sw_stable    : debounced levels, feed dipsw_pio_external_connection_export
//   sw_change    : one-cycle pulse per bit when sw_stable changes
//   sw_valid     : high once the start-up window has completed
//   stm_hwevents : [27:0] registered STM event vector, present only when
//                  DIPSW_DEBOUNCE_STM_EVENT_EN is defined:
//                  [WIDTH-1:0] = sw_change, [2*WIDTH-1:WIDTH] = sw_stable,
//                  [27] = sw_valid, others 0; one cycle behind the sources.
//
// Build option
//   DIPSW_DEBOUNCE_STM_EVENT_EN : adds the stm_hwevents port and register.
// -----------------------------------------------------------------------------
module dipsw_debounce
    import dipsw_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [WIDTH-1:0]       sw_async,
    output logic [WIDTH-1:0]       sw_stable,
    output logic [WIDTH-1:0]       sw_change,
    output logic                   sw_valid
`ifdef DIPSW_DEBOUNCE_STM_EVENT_EN
    ,
    output logic [STM_EVENT_W-1:0] stm_hwevents
`endif
);

    // Derived; not intended as an override point.
    localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    glb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] init_cnt_reg, init_cnt_next;
    logic             init_load;
    logic             run_en;

    // Global FSM: state register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    // Global FSM: next state. RUN is terminal until reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT:    if (init_cnt_reg == INIT_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    // Global FSM: outputs. The last INIT cycle strobes init_load so every
    // bit captures its synchronized level at the same edge.
    always_comb begin
        init_cnt_next = init_cnt_reg;
        init_load     = 1'b0;
        run_en        = 1'b0;
        case (state_reg)
            INIT: begin
                if (init_cnt_reg == INIT_LAST) begin
                    init_load     = 1'b1;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + CNT_W'(1);
                end
            end
            RUN:     run_en = 1'b1;
            default: init_cnt_next = '0;
        endcase
    end

    // sw_valid is a direct decode of the state flop.
    assign sw_valid = run_en;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk_clk     (clk_clk),
            .reset_reset (reset_reset),
            .sw_async    (sw_async[gi]),
            .run_en      (run_en),
            .init_load   (init_load),
            .stable      (sw_stable[gi]),
            .change      (sw_change[gi])
        );
    end

`ifdef DIPSW_DEBOUNCE_STM_EVENT_EN
    logic [STM_EVENT_W-1:0] stm_reg, stm_next;

    always_comb begin
        stm_next                      = '0;
        stm_next[WIDTH-1:0]           = sw_change;
        stm_next[2*WIDTH-1:WIDTH]     = sw_stable;
        stm_next[STM_VALID_BIT]       = sw_valid;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stm_reg <= '0;
        end else begin
            stm_reg <= stm_next;
        end
    end

    assign stm_hwevents = stm_reg;
`endif

endmodule : dipsw_debounce
